// File: rtl/nasti_txn_scheduler.sv
// -----------------------------------------------------------------------------
// nasti_txn_scheduler
//   Core-clock scheduler sitting behind the NASTI frontend FIFOs. Pops AR/AW
//   bursts, arbitrates read vs write round-robin, and expands each burst into
//   per-beat commands for the DDR command backend. Write bursts finish with a
//   B response push; reads are throttled by an outstanding-burst counter that
//   the read-data path releases with rd_burst_done.
//
// Ports (all logic on rising core_clk, core_rst synchronous active high):
//   ar_rdata/ar_rempty/ar_rden   AR FIFO head (show-ahead) / empty / pop
//   aw_rdata/aw_rempty/aw_rden   AW FIFO head (show-ahead) / empty / pop
//   w_rdata/w_rempty/w_rden      W FIFO head (show-ahead) / empty / pop
//   b_wdata/b_wfull/b_wren       B FIFO write data / full / push
//   cmd_valid/cmd_ready          beat command handshake to the backend
//   cmd_write/addr/id/last       beat direction, byte address, burst id, last
//   cmd_wdata/cmd_wstrb          write data / strobe (strobe 0 on reads)
//   rd_burst_done                one read burst fully returned on R path
//   rd_pending                   read bursts issued but not yet returned
//
// FIFO word layouts (MSB first):
//   ar/aw : {id, addr, len[7:0], size[2:0], burst[1:0], user}
//   w     : {data, strb, last}
//   b     : {id, resp[1:0], user}
// -----------------------------------------------------------------------------
module nasti_txn_scheduler #(
  parameter int C_NASTI_ID_WIDTH   = 4,
  parameter int C_NASTI_ADDR_WIDTH = 32,
  parameter int C_NASTI_DATA_WIDTH = 64,
  parameter int C_NASTI_USER_WIDTH = 1,
  parameter int C_MAX_PENDING      = 5,
  parameter int C_WR_FIRST         = 1,
  localparam int STRB_W = C_NASTI_DATA_WIDTH / 8,
  localparam int AX_W   = C_NASTI_ID_WIDTH + C_NASTI_ADDR_WIDTH + 13 + C_NASTI_USER_WIDTH,
  localparam int W_W    = C_NASTI_DATA_WIDTH + STRB_W + 1,
  localparam int B_W    = C_NASTI_ID_WIDTH + 2 + C_NASTI_USER_WIDTH,
  localparam int PEND_W = $clog2(C_MAX_PENDING + 1)
) (
  input  logic                          core_clk,
  input  logic                          core_rst,
  input  logic [AX_W-1:0]               ar_rdata,
  input  logic                          ar_rempty,
  output logic                          ar_rden,
  input  logic [AX_W-1:0]               aw_rdata,
  input  logic                          aw_rempty,
  output logic                          aw_rden,
  input  logic [W_W-1:0]                w_rdata,
  input  logic                          w_rempty,
  output logic                          w_rden,
  output logic [B_W-1:0]                b_wdata,
  input  logic                          b_wfull,
  output logic                          b_wren,
  output logic                          cmd_valid,
  input  logic                          cmd_ready,
  output logic                          cmd_write,
  output logic [C_NASTI_ADDR_WIDTH-1:0] cmd_addr,
  output logic [C_NASTI_ID_WIDTH-1:0]   cmd_id,
  output logic                          cmd_last,
  output logic [C_NASTI_DATA_WIDTH-1:0] cmd_wdata,
  output logic [STRB_W-1:0]             cmd_wstrb,
  input  logic                          rd_burst_done,
  output logic [PEND_W-1:0]             rd_pending
);

  localparam int ADDR_W = C_NASTI_ADDR_WIDTH;

  typedef struct packed {
    logic [C_NASTI_ID_WIDTH-1:0]   id;
    logic [ADDR_W-1:0]             addr;
    logic [7:0]                    len;
    logic [2:0]                    size;
    logic [1:0]                    burst;
    logic [C_NASTI_USER_WIDTH-1:0] user;
  } ax_t;

  typedef struct packed {
    logic [C_NASTI_DATA_WIDTH-1:0] data;
    logic [STRB_W-1:0]             strb;
    logic                          last;
  } w_t;

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST} state_e;

  ax_t    ar, aw, sel;
  w_t     w;
  state_e state_q, state_d;

  logic [C_NASTI_ID_WIDTH-1:0]   id_q;
  logic [ADDR_W-1:0]             addr_q, addr_next, addr_inc, wrap_mask;
  logic [7:0]                    len_q, beats_left_q;
  logic [2:0]                    size_q;
  logic [1:0]                    burst_q;
  logic [C_NASTI_USER_WIDTH-1:0] user_q;
  logic                          err_q, last_wr_q;
  logic                          rd_req, wr_req, grant_rd, grant_wr;
  logic                          beat_last, accept, pend_inc, pend_dec;

  assign ar  = ar_rdata;
  assign aw  = aw_rdata;
  assign w   = w_rdata;
  assign sel = grant_wr ? aw : ar;

  // B space is reserved at grant time: this block is the B FIFO's only writer,
  // so a non-full FIFO at grant guarantees room for the response.
  assign rd_req    = !ar_rempty && (rd_pending < PEND_W'(C_MAX_PENDING));
  assign wr_req    = !aw_rempty && !b_wfull;
  assign grant_wr  = !core_rst && (state_q == IDLE) && wr_req && (!rd_req || !last_wr_q);
  assign grant_rd  = !core_rst && (state_q == IDLE) && rd_req && !grant_wr;
  assign beat_last = (beats_left_q == 8'd0);
  assign accept    = cmd_valid && cmd_ready;
  assign pend_inc  = accept && !cmd_write && beat_last;
  assign pend_dec  = rd_burst_done && (rd_pending != '0);

  // WRAP bursts step inside a (len+1)<<size aligned window: the high address
  // bits stay put and only the in-window offset rolls over.
  assign addr_inc  = addr_q + (ADDR_W'(1) << size_q);
  assign wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);

  always_comb begin
    case (burst_q)
      2'd0:    addr_next = addr_q;
      2'd2:    addr_next = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default: addr_next = addr_inc;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (core_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    ar_rden   = 1'b0;
    aw_rden   = 1'b0;
    w_rden    = 1'b0;
    b_wren    = 1'b0;
    b_wdata   = '0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_id    = '0;
    cmd_last  = 1'b0;
    cmd_wdata = '0;
    cmd_wstrb = '0;
    // Outputs are forced quiet while reset is held so an abandoned burst
    // cannot push a B response or pop a FIFO on its way out.
    if (!core_rst) begin
      case (state_q)
        IDLE: begin
          ar_rden = grant_rd;
          aw_rden = grant_wr;
          if (grant_wr)      state_d = WR_BURST;
          else if (grant_rd) state_d = RD_BURST;
        end
        RD_BURST: begin
          cmd_valid = 1'b1;
          cmd_addr  = addr_q;
          cmd_id    = id_q;
          cmd_last  = beat_last;
          if (cmd_ready && beat_last) state_d = IDLE;
        end
        WR_BURST: begin
          cmd_valid = !w_rempty;
          cmd_write = 1'b1;
          cmd_addr  = addr_q;
          cmd_id    = id_q;
          cmd_last  = beat_last;
          cmd_wdata = w.data;
          cmd_wstrb = w.strb;
          w_rden    = !w_rempty && cmd_ready;
          if (w_rden && beat_last) begin
            b_wren  = 1'b1;
            // SLVERR when any beat's w_last disagreed with the expected last.
            b_wdata = {id_q, (err_q || (w.last != beat_last)) ? 2'b10 : 2'b00, user_q};
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge core_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees pre-edge values regardless of statement order.
    if (core_rst) begin
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      user_q       <= '0;
      beats_left_q <= '0;
      err_q        <= 1'b0;
      last_wr_q    <= (C_WR_FIRST == 0);
      rd_pending   <= '0;
    end else begin
      if (grant_wr || grant_rd) begin
        id_q         <= sel.id;
        addr_q       <= sel.addr;
        len_q        <= sel.len;
        size_q       <= sel.size;
        burst_q      <= sel.burst;
        user_q       <= sel.user;
        beats_left_q <= sel.len;
        err_q        <= 1'b0;
        last_wr_q    <= grant_wr;
      end else if (accept) begin
        beats_left_q <= beats_left_q - 8'd1;
        addr_q       <= addr_next;
        if (cmd_write && (w.last != beat_last)) err_q <= 1'b1;
      end
      // Issue and release in the same cycle cancel out.
      if (pend_inc && !pend_dec)      rd_pending <= rd_pending + PEND_W'(1);
      else if (pend_dec && !pend_inc) rd_pending <= rd_pending - PEND_W'(1);
    end
  end

endmodule

// File: tb/tb_nasti_txn_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nasti_txn_scheduler
//   Self-checking bench for nasti_txn_scheduler. Models the show-ahead AR/AW/W
//   FIFOs with queues, keeps a scoreboard of expected beat commands and B
//   responses, and runs a burst vector table plus hand-written sequences for
//   arbitration, read throttling, W starvation and mid-burst reset.
// -----------------------------------------------------------------------------
module tb_nasti_txn_scheduler;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int USER_W = 2;
  localparam int STRB_W = DATA_W / 8;
  localparam int MAXP   = 5;
  localparam int PEND_W = 3;
  localparam int AX_W   = ID_W + ADDR_W + 13 + USER_W;
  localparam int W_W    = DATA_W + STRB_W + 1;
  localparam int B_W    = ID_W + 2 + USER_W;

  logic              core_clk = 1'b0;
  logic              core_rst;
  logic [AX_W-1:0]   ar_rdata, aw_rdata;
  logic              ar_rempty, aw_rempty, w_rempty;
  logic              ar_rden, aw_rden, w_rden;
  logic [W_W-1:0]    w_rdata;
  logic [B_W-1:0]    b_wdata;
  logic              b_wfull, b_wren;
  logic              cmd_valid, cmd_ready, cmd_write, cmd_last;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ID_W-1:0]   cmd_id;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_wstrb;
  logic              rd_burst_done;
  logic [PEND_W-1:0] rd_pending;

  nasti_txn_scheduler #(
    .C_NASTI_ID_WIDTH(ID_W), .C_NASTI_ADDR_WIDTH(ADDR_W),
    .C_NASTI_DATA_WIDTH(DATA_W), .C_NASTI_USER_WIDTH(USER_W),
    .C_MAX_PENDING(MAXP), .C_WR_FIRST(1)
  ) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .ar_rdata(ar_rdata), .ar_rempty(ar_rempty), .ar_rden(ar_rden),
    .aw_rdata(aw_rdata), .aw_rempty(aw_rempty), .aw_rden(aw_rden),
    .w_rdata(w_rdata), .w_rempty(w_rempty), .w_rden(w_rden),
    .b_wdata(b_wdata), .b_wfull(b_wfull), .b_wren(b_wren),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_id(cmd_id), .cmd_last(cmd_last),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rd_burst_done(rd_burst_done), .rd_pending(rd_pending)
  );

  always #5 core_clk = ~core_clk;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [ID_W-1:0]   id;
    logic [USER_W-1:0] user;
    logic [0:3][ADDR_W-1:0] exp_addr;
  } vec_t;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
    logic              last;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } cmd_t;

  logic [AX_W-1:0] ar_q[$], aw_q[$];
  logic [W_W-1:0]  w_q[$], pend_w[$];
  cmd_t            exp_cmd[$];
  logic [B_W-1:0]  exp_b[$];
  bit              grant_log[$];

  int checks = 0, failures = 0;
  int beat_count = 0, b_count = 0;
  bit pop_ar = 0, pop_aw = 0, pop_w = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: actual=event required=none", name);
  endtask

  task automatic refresh();
    ar_rempty = (ar_q.size() == 0);
    aw_rempty = (aw_q.size() == 0);
    w_rempty  = (w_q.size() == 0);
    ar_rdata  = ar_rempty ? '0 : ar_q[0];
    aw_rdata  = aw_rempty ? '0 : aw_q[0];
    w_rdata   = w_rempty  ? '0 : w_q[0];
  endtask

  task automatic step();
    @(posedge core_clk);
    #2;
  endtask

  function automatic vec_t mk(input logic wr, input logic [ADDR_W-1:0] addr,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst, input logic [ID_W-1:0] id,
                              input logic [USER_W-1:0] user,
                              input logic [ADDR_W-1:0] a0, a1, a2, a3);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
    v.id = id; v.user = user; v.exp_addr = {a0, a1, a2, a3};
    return v;
  endfunction

  // Queues the burst on AR or AW and its expected beats (and B) on the
  // scoreboard. W beats go to the W FIFO, or to pend_w for paced delivery.
  task automatic push_burst(input vec_t v, input int bad_last, input bit with_w);
    cmd_t c;
    logic wl;
    logic [AX_W-1:0] ax;
    ax = {v.id, v.addr, v.len, v.size, v.burst, v.user};
    if (v.wr) aw_q.push_back(ax);
    else      ar_q.push_back(ax);
    for (int b = 0; b <= int'(v.len); b++) begin
      c.wr   = v.wr;
      c.addr = v.exp_addr[b];
      c.id   = v.id;
      c.last = (b == int'(v.len));
      if (v.wr) begin
        c.wdata = {$urandom, $urandom};
        c.wstrb = STRB_W'($urandom);
        wl = c.last ^ (b == bad_last);
        if (with_w) w_q.push_back({c.wdata, c.wstrb, wl});
        else        pend_w.push_back({c.wdata, c.wstrb, wl});
      end else begin
        c.wdata = '0;
        c.wstrb = '0;
      end
      exp_cmd.push_back(c);
    end
    if (v.wr) exp_b.push_back({v.id, (bad_last >= 0) ? 2'b10 : 2'b00, v.user});
    refresh();
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while ((exp_cmd.size() != 0 || exp_b.size() != 0) && n < bound) begin
      step();
      n++;
    end
    check(name, exp_cmd.size() + exp_b.size(), 0);
  endtask

  task automatic pulse_done(input int n);
    for (int i = 0; i < n; i++) begin
      rd_burst_done = 1'b1;
      step();
      rd_burst_done = 1'b0;
      step();
    end
  endtask

  // Monitor: sampled mid-cycle, away from the active edge.
  logic              stall_q = 1'b0;
  logic [ADDR_W-1:0] st_addr;
  logic [ID_W-1:0]   st_id;
  logic              st_last;
  logic [DATA_W-1:0] st_wdata;
  logic [STRB_W-1:0] st_wstrb;

  always @(negedge core_clk) begin
    cmd_t c;
    logic [B_W-1:0] eb;
    pop_ar = ar_rden;
    pop_aw = aw_rden;
    pop_w  = w_rden;
    if (ar_rden) grant_log.push_back(1'b0);
    if (aw_rden) grant_log.push_back(1'b1);
    if (b_wren) begin
      b_count++;
      if (exp_b.size() == 0) flag_fail("b_unexpected");
      else begin
        eb = exp_b.pop_front();
        check("b_wdata", b_wdata, eb);
      end
    end
    if (stall_q && cmd_valid) begin
      check("stall_addr", cmd_addr, st_addr);
      check("stall_id", cmd_id, st_id);
      check("stall_last", cmd_last, st_last);
      check("stall_wdata", cmd_wdata, st_wdata);
      check("stall_wstrb", cmd_wstrb, st_wstrb);
    end
    if (cmd_valid && cmd_ready) begin
      beat_count++;
      if (exp_cmd.size() == 0) flag_fail("cmd_unexpected");
      else begin
        c = exp_cmd.pop_front();
        check("cmd_write", cmd_write, c.wr);
        check("cmd_addr", cmd_addr, c.addr);
        check("cmd_id", cmd_id, c.id);
        check("cmd_last", cmd_last, c.last);
        check("cmd_wstrb", cmd_wstrb, c.wstrb);
        if (c.wr) check("cmd_wdata", cmd_wdata, c.wdata);
      end
    end
    stall_q  = cmd_valid && !cmd_ready;
    st_addr  = cmd_addr;
    st_id    = cmd_id;
    st_last  = cmd_last;
    st_wdata = cmd_wdata;
    st_wstrb = cmd_wstrb;
  end

  // FIFO pops take effect just after the edge that sampled the rden pulse.
  always @(posedge core_clk) begin
    #1;
    if (pop_ar) begin
      if (ar_q.size() != 0) ar_q.delete(0); else flag_fail("ar_pop_empty");
    end
    if (pop_aw) begin
      if (aw_q.size() != 0) aw_q.delete(0); else flag_fail("aw_pop_empty");
    end
    if (pop_w) begin
      if (w_q.size() != 0) w_q.delete(0); else flag_fail("w_pop_empty");
    end
    refresh();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_quiet(input string tag);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_ar_rden"}, ar_rden, 0);
    check({tag, "_aw_rden"}, aw_rden, 0);
    check({tag, "_w_rden"}, w_rden, 0);
    check({tag, "_b_wren"}, b_wren, 0);
    check({tag, "_b_wdata"}, b_wdata, 0);
    check({tag, "_cmd_addr"}, cmd_addr, 0);
    check({tag, "_cmd_id"}, cmd_id, 0);
    check({tag, "_cmd_last"}, cmd_last, 0);
    check({tag, "_cmd_write"}, cmd_write, 0);
    check({tag, "_cmd_wstrb"}, cmd_wstrb, 0);
    check({tag, "_cmd_wdata"}, cmd_wdata, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int bc, n0, k;
    vecs[0] = mk(1, 32'h100,  3, 3, 1, 4'h1, 2'd1, 32'h100, 32'h108, 32'h110, 32'h118);
    vecs[1] = mk(0, 32'h38,   3, 3, 2, 4'h2, 2'd0, 32'h38,  32'h20,  32'h28,  32'h30);
    vecs[2] = mk(0, 32'h40,   2, 2, 0, 4'h3, 2'd2, 32'h40,  32'h40,  32'h40,  32'h0);
    vecs[3] = mk(0, 32'h10,   1, 2, 3, 4'h4, 2'd3, 32'h10,  32'h14,  32'h0,   32'h0);
    vecs[4] = mk(1, 32'h1C,   1, 2, 2, 4'h5, 2'd2, 32'h1C,  32'h18,  32'h0,   32'h0);
    vecs[5] = mk(0, 32'h7,    0, 0, 1, 4'h6, 2'd1, 32'h7,   32'h0,   32'h0,   32'h0);
    vecs[6] = mk(0, 32'h4,    3, 2, 2, 4'h7, 2'd0, 32'h4,   32'h8,   32'hC,   32'h0);
    vecs[7] = mk(1, 32'h1000, 2, 0, 1, 4'h8, 2'd3, 32'h1000, 32'h1001, 32'h1002, 32'h0);

    core_rst = 1'b1; cmd_ready = 1'b1; b_wfull = 1'b0; rd_burst_done = 1'b0;
    refresh();
    repeat (3) step();
    core_rst = 1'b0;
    step();
    check_quiet("reset");
    check("reset_rd_pending", rd_pending, 0);

    // Burst table: address sequences for every burst type.
    foreach (vecs[i]) begin
      push_burst(vecs[i], -1, 1'b1);
      wait_drain("vec_drain", 40);
      if (!vecs[i].wr) begin
        step();
        check("vec_rd_pending_inc", rd_pending, 1);
        pulse_done(1);
        check("vec_rd_pending_dec", rd_pending, 0);
      end
    end

    // Arbitration: both sides pending out of reset, write wins first.
    core_rst = 1'b1;
    step();
    grant_log.delete();
    for (int i = 0; i < 3; i++) begin
      push_burst(mk(1, 32'h400 + 32'(i * 16), 0, 3, 1, 4'(8 + i), 2'(i),
                    32'h400 + 32'(i * 16), 0, 0, 0), -1, 1'b1);
      push_burst(mk(0, 32'h500 + 32'(i * 16), 0, 3, 1, 4'(i), 2'(i),
                    32'h500 + 32'(i * 16), 0, 0, 0), -1, 1'b1);
    end
    step();
    core_rst = 1'b0;
    wait_drain("arb_drain", 80);
    check("arb_grant_count", grant_log.size(), 6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("arb_grant_order", grant_log[i], (i % 2 == 0) ? 1 : 0);
    check("arb_rd_pending", rd_pending, 3);
    pulse_done(4);
    check("arb_no_underflow", rd_pending, 0);

    // Read throttling at C_MAX_PENDING.
    for (int i = 0; i < 6; i++)
      push_burst(mk(0, 32'h800 + 32'(i * 8), 0, 3, 1, 4'(i), 2'd0,
                    32'h800 + 32'(i * 8), 0, 0, 0), -1, 1'b1);
    repeat (40) step();
    check("limit_rd_pending", rd_pending, MAXP);
    check("limit_ar_held", ar_q.size(), 1);
    check("limit_cmd_left", exp_cmd.size(), 1);
    cmd_ready = 1'b0;
    rd_burst_done = 1'b1;
    step();
    rd_burst_done = 1'b0;
    check("limit_after_done", rd_pending, 4);
    repeat (3) step();
    check("limit_sixth_popped", ar_q.size(), 0);
    check("limit_sixth_stalled", cmd_valid, 1);
    cmd_ready = 1'b1;
    rd_burst_done = 1'b1;
    step();
    rd_burst_done = 1'b0;
    check("limit_inc_dec_same", rd_pending, 4);
    push_burst(mk(0, 32'h900, 0, 3, 1, 4'hF, 2'd0, 32'h900, 0, 0, 0), -1, 1'b1);
    wait_drain("limit_drain", 20);
    check("limit_refill", rd_pending, MAXP);
    pulse_done(6);
    check("limit_cleared", rd_pending, 0);

    // W starvation with toggling cmd_ready and a misplaced w_last.
    push_burst(mk(1, 32'h200, 3, 2, 1, 4'hA, 2'd1, 32'h200, 32'h204, 32'h208, 32'h20C),
               1, 1'b0);
    k = 0;
    while ((exp_cmd.size() != 0 || exp_b.size() != 0) && k < 120) begin
      cmd_ready = k[0];
      if (k % 3 == 2 && pend_w.size() != 0) w_q.push_back(pend_w.pop_front());
      refresh();
      #1;
      if (w_q.size() == 0) begin
        check("wstall_valid", cmd_valid, 0);
        check("wstall_rden", w_rden, 0);
      end
      step();
      k++;
    end
    check("wstall_drain", exp_cmd.size() + exp_b.size(), 0);
    cmd_ready = 1'b1;
    step();

    // Reset on beat 2 of a write: burst abandoned, no B push.
    bc = b_count;
    n0 = beat_count;
    push_burst(mk(1, 32'h300, 3, 3, 1, 4'hC, 2'd2, 32'h300, 32'h308, 32'h310, 32'h318),
               -1, 1'b1);
    k = 0;
    while (beat_count == n0 && k < 20) begin
      step();
      k++;
    end
    check("rst_first_beat_seen", beat_count - n0, 1);
    core_rst = 1'b1;
    step();
    check_quiet("rst_mid");
    ar_q.delete(); aw_q.delete(); w_q.delete();
    exp_cmd.delete(); exp_b.delete();
    refresh();
    core_rst = 1'b0;
    step();
    check_quiet("rst_after");
    check("rst_rd_pending", rd_pending, 0);
    check("rst_no_b_push", b_count - bc, 0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
